snoop_sram_arb: RTL and testbench
=================================

SNOOP_SRAM_ARB -- requirements
Module: snoop_sram_arb

Interface
REQ-001 SHALL have parameter NR_PORTS, default 4, number of SRAM requesters; port 0 is the snoop controller, ports 1..NR_PORTS-1 are the cache controllers and the miss handler.
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum cycles one owner keeps the SRAM while another port waits.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_i, input, NR_PORTS x DCACHE_SET_ASSOC, per-port way request; a port requests when any bit is set.
REQ-006 SHALL have ports addr_i (DCACHE_INDEX_WIDTH), tag_i (DCACHE_TAG_WIDTH), data_i (cache_line_t), be_i (cl_be_t) and we_i (1), all inputs, one per port.
REQ-007 SHALL have port gnt_o, output, NR_PORTS, per-port grant.
REQ-008 SHALL have ports req_o, addr_o, tag_o, data_o, be_o and we_o, all outputs, the muxed SRAM request.
REQ-009 SHALL have port gnt_i, input, 1, SRAM grant.
REQ-010 SHALL have port updating_cache_o, output, NR_PORTS, bit i set when a port other than i owns the SRAM with we set.
REQ-011 SHALL have port owner_o, output, $clog2(NR_PORTS), index of the current owner, for debug.

Function
REQ-012 SHALL implement FSM states IDLE and OWNED.
REQ-013 IDLE: SHALL pick a winner among requesting ports in the same cycle, drive the winner's signals to the SRAM combinationally and set gnt_o[winner]=gnt_i.
REQ-014 SHALL go IDLE->OWNED at the first cycle where gnt_i=1 while req_o is nonzero.
REQ-015 OWNED: SHALL hold the owner while req_i[owner] is nonzero and route only the owner; all other gnt_o bits SHALL be 0.
REQ-016 SHALL go OWNED->IDLE in the cycle req_i[owner] becomes all zero; a new winner SHALL be chosen in that same cycle, with zero bubble.
REQ-017 Winner selection SHALL be round-robin, starting at the port after the last owner; the pointer SHALL update on every IDLE->OWNED transition.
REQ-018 Hold counter SHALL increment each OWNED cycle in which another port requests, and SHALL clear on ownership change.
REQ-019 When the hold counter reaches MAX_HOLD, ownership SHALL be revoked at the next cycle in which the owner's gnt_i handshake completes, and the FSM SHALL go to IDLE.
REQ-020 No requester SHALL ever drive req_o while its gnt_o is low; gnt_o SHALL be one-hot or zero.
REQ-021 If the owner's request drops in the same cycle another port raises its request, the newcomer SHALL be eligible immediately.
REQ-022 When no port requests, req_o, we_o, be_o and data_o SHALL be '0.

Reset
REQ-023 During reset, state SHALL be IDLE, RR pointer 0, hold counter 0, and owner_o, gnt_o, req_o, we_o and updating_cache_o all '0.
REQ-024 Reset asserted mid-ownership SHALL drop the grant asynchronously; no SRAM write SHALL be in flight after rst_ni rises.

Configuration
REQ-025 With SNOOP_SRAM_PRIO_EN defined, port 0 SHALL win every IDLE arbitration it requests in and SHALL be exempt from MAX_HOLD revocation; round-robin SHALL apply only among ports 1..NR_PORTS-1.
REQ-026 Without SNOOP_SRAM_PRIO_EN, all ports SHALL be pure round-robin under the same MAX_HOLD rule.

Structure
REQ-027 NR_PORTS default and the arb state_t enum SHALL live in std_cache_pkg; cache_line_t and cl_be_t SHALL be reused from that package.
REQ-028 Round-robin selection SHALL be one sub-module, rr_prio_sel, taking a request vector and pointer and returning one-hot grant plus index.

Verification
REQ-029 Ports 1 and 2 request simultaneously after reset, gnt_i=1 -> port 1 granted, then port 2 granted in the cycle port 1 drops.
REQ-030 Port 3 writes (we=1) and holds 3 cycles -> updating_cache_o=4'b0111 for those cycles, and 0 after release.
REQ-031 Port 1 holds for 40 cycles with port 2 waiting and MAX_HOLD=16 -> port 1 revoked after 16 waiting cycles, port 2 granted the next cycle.
REQ-032 SNOOP_SRAM_PRIO_EN defined, ports 0 and 1 request together with pointer=1 -> port 0 wins; without the macro, port 1 wins.
REQ-033 rst_ni pulled low while port 2 is OWNED with gnt_i=1 -> gnt_o=0 and req_o=0 immediately; after reset, port 2 is re-granted only after re-requesting.
REQ-034 gnt_i held 0 for 5 cycles with port 1 requesting -> FSM stays IDLE, gnt_o[1]=0, req_o stable and equal to port 1's request.

Source files
------------

// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared data-cache geometry, line types and snoop SRAM arbiter defaults
package std_cache_pkg;
    localparam int unsigned DCACHE_SET_ASSOC   = 4;
    localparam int unsigned DCACHE_INDEX_WIDTH = 8;
    localparam int unsigned DCACHE_TAG_WIDTH   = 16;
    localparam int unsigned DCACHE_LINE_WIDTH  = 32;
    localparam int unsigned ARB_NR_PORTS       = 4;
    typedef logic [DCACHE_LINE_WIDTH-1:0]   cache_line_t;
    typedef logic [DCACHE_LINE_WIDTH/8-1:0] cl_be_t;
    typedef enum logic {IDLE, OWNED} state_t;
endpackage

// File: rtl/snoop_sram_arb_rr.sv
// rr_prio_sel: round-robin pick of the first requester at or after ptr_i, as one-hot and index
module rr_prio_sel #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0] p;
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        p       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            p = IW'((int'(ptr_i) + k) % N);
            if (req_i[p]) begin
                idx_o   = p;
                valid_o = 1'b1;
            end
        end
    end
    assign gnt_o = valid_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/snoop_sram_arb.sv
// snoop_sram_arb: round-robin SRAM arbiter with ownership hold and MAX_HOLD revocation; SNOOP_SRAM_PRIO_EN gives port 0 (snoop) priority
module snoop_sram_arb
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS = ARB_NR_PORTS,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NR_PORTS-1:0][DCACHE_SET_ASSOC-1:0]     req_i,
    input  logic [NR_PORTS-1:0][DCACHE_INDEX_WIDTH-1:0]   addr_i,
    input  logic [NR_PORTS-1:0][DCACHE_TAG_WIDTH-1:0]     tag_i,
    input  cache_line_t [NR_PORTS-1:0]                    data_i,
    input  cl_be_t [NR_PORTS-1:0]                         be_i,
    input  logic [NR_PORTS-1:0]                           we_i,
    output logic [NR_PORTS-1:0]                           gnt_o,
    output logic [DCACHE_SET_ASSOC-1:0]                   req_o,
    output logic [DCACHE_INDEX_WIDTH-1:0]                 addr_o,
    output logic [DCACHE_TAG_WIDTH-1:0]                   tag_o,
    output cache_line_t                                   data_o,
    output cl_be_t                                        be_o,
    output logic                                          we_o,
    input  logic                                          gnt_i,
    output logic [NR_PORTS-1:0]                           updating_cache_o,
    output logic [$clog2(NR_PORTS)-1:0]                   owner_o
);
    localparam int unsigned IW = $clog2(NR_PORTS);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d, ptr_q, ptr_d, arb_idx, sel;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NR_PORTS-1:0] port_req, arb_req, arb_gnt, owner_oh;
    logic              own_active, others_req, arb_valid, sel_valid, exempt;

    for (genvar i = 0; i < NR_PORTS; i++) begin : g_port
        assign port_req[i]         = |req_i[i];
        assign updating_cache_o[i] = rst_ni && own_active && we_i[owner_q] && owner_q != IW'(i);
    end

    assign owner_oh   = NR_PORTS'(1) << owner_q;
    assign own_active = state_q == OWNED && port_req[owner_q];
    assign others_req = |(port_req & ~owner_oh);

`ifdef SNOOP_SRAM_PRIO_EN
    assign arb_req = port_req[0] ? NR_PORTS'(1) : port_req;
    assign exempt  = owner_q == '0;
`else
    assign arb_req = port_req;
    assign exempt  = 1'b0;
`endif

    rr_prio_sel #(.N(NR_PORTS)) u_rr_prio_sel (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // reset gates the outputs combinationally so the grant drops without waiting for a clock
    assign sel       = own_active ? owner_q : arb_idx;
    assign sel_valid = rst_ni && (own_active || arb_valid);
    assign gnt_o     = sel_valid ? (own_active ? owner_oh : arb_gnt) & {NR_PORTS{gnt_i}} : '0;
    assign req_o     = sel_valid ? req_i[sel]  : '0;
    assign addr_o    = sel_valid ? addr_i[sel] : '0;
    assign tag_o     = sel_valid ? tag_i[sel]  : '0;
    assign data_o    = sel_valid ? data_i[sel] : '0;
    assign be_o      = sel_valid ? be_i[sel]   : '0;
    assign we_o      = sel_valid && we_i[sel];
    assign owner_o   = owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (own_active) begin
            if (others_req && hold_q != HW'(MAX_HOLD)) hold_d = hold_q + 1'b1;
            if (hold_q == HW'(MAX_HOLD) && !exempt && gnt_i) begin
                state_d = IDLE;
                hold_d  = '0;
            end
        end else begin
            // idle, or the owner just released: arbitrate this cycle with no bubble
            state_d = IDLE;
            hold_d  = '0;
            if (arb_valid && gnt_i) begin
                state_d = OWNED;
                owner_d = arb_idx;
                ptr_d   = (arb_idx == IW'(NR_PORTS - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: tb/tb_snoop_sram_arb.sv
// tb_snoop_sram_arb: directed vector table plus hand sequences for hold revocation and async reset
module tb_snoop_sram_arb;
    import std_cache_pkg::*;
    localparam int N = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic gnt_i = 1'b0;
    logic [N-1:0][DCACHE_SET_ASSOC-1:0]   req_i;
    logic [N-1:0][DCACHE_INDEX_WIDTH-1:0] addr_i;
    logic [N-1:0][DCACHE_TAG_WIDTH-1:0]   tag_i;
    cache_line_t [N-1:0]                  data_i;
    cl_be_t [N-1:0]                       be_i;
    logic [N-1:0]                         we_i;
    logic [N-1:0]                         gnt_o;
    logic [DCACHE_SET_ASSOC-1:0]          req_o;
    logic [DCACHE_INDEX_WIDTH-1:0]        addr_o;
    logic [DCACHE_TAG_WIDTH-1:0]          tag_o;
    cache_line_t                          data_o;
    cl_be_t                               be_o;
    logic                                 we_o;
    logic [N-1:0]                         updating_cache_o;
    logic [1:0]                           owner_o;
    logic [3:0]                           we_drv;

    int passed = 0;
    int total = 0;

    typedef struct {
        string      nm;
        logic [3:0] rq;
        logic [3:0] we;
        logic       gi;
        logic [3:0] e_gnt;
        int         e_sel;
        logic [3:0] e_upd;
    } vec_t;
    vec_t vt[$];

    snoop_sram_arb dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .addr_i           (addr_i),
        .tag_i            (tag_i),
        .data_i           (data_i),
        .be_i             (be_i),
        .we_i             (we_i),
        .gnt_o            (gnt_o),
        .req_o            (req_o),
        .addr_o           (addr_o),
        .tag_o            (tag_o),
        .data_o           (data_o),
        .be_o             (be_o),
        .we_o             (we_o),
        .gnt_i            (gnt_i),
        .updating_cache_o (updating_cache_o),
        .owner_o          (owner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] we, input logic gi);
        for (int p = 0; p < N; p++) begin
            req_i[p] = rq[p] ? 4'(p + 1) : 4'h0;
            we_i[p]  = we[p];
        end
        we_drv = we;
        gnt_i  = gi;
    endtask

    function automatic logic [127:0] route(input int s);
        if (s < 0) return '0;
        return {4'(s + 1), 8'(16 + s), 16'(16'hBE00 + s), 32'(32'hA5A5_0000 + s), 4'hF ^ 4'(s), we_drv[s]};
    endfunction

    task automatic check(input string name, input logic [3:0] e_gnt, input int e_sel, input logic [3:0] e_upd);
        cmp({name, ".gnt"}, 128'(gnt_o), 128'(e_gnt));
        cmp({name, ".route"}, 128'({req_o, addr_o, tag_o, data_o, be_o, we_o}), route(e_sel));
        cmp({name, ".upd"}, 128'(updating_cache_o), 128'(e_upd));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        drive(4'hF, 4'hF, 1'b1);
        #1;
        check("rst", 4'h0, -1, 4'h0);
        cmp("rst.owner", 128'(owner_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(4'h0, 4'h0, 1'b1);
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            addr_i[p] = 8'(16 + p);
            tag_i[p]  = 16'(16'hBE00 + p);
            data_i[p] = 32'(32'hA5A5_0000 + p);
            be_i[p]   = 4'hF ^ 4'(p);
        end
        drive(4'h0, 4'h0, 1'b0);

        vt.push_back('{"p1p2_arb",   4'b0110, 4'b0000, 1'b1, 4'b0010,  1, 4'b0000});
        vt.push_back('{"p1_hold",    4'b0110, 4'b0000, 1'b1, 4'b0010,  1, 4'b0000});
        vt.push_back('{"p2_handoff", 4'b0100, 4'b0000, 1'b1, 4'b0100,  2, 4'b0000});
        vt.push_back('{"p2_owned",   4'b0100, 4'b0000, 1'b1, 4'b0100,  2, 4'b0000});
        vt.push_back('{"idle_zero",  4'b0000, 4'b0000, 1'b1, 4'b0000, -1, 4'b0000});
        for (int k = 0; k < 5; k++)
            vt.push_back('{"no_gnt", 4'b0010, 4'b0000, 1'b0, 4'b0000,  1, 4'b0000});
        vt.push_back('{"gnt_late",   4'b0010, 4'b0000, 1'b1, 4'b0010,  1, 4'b0000});
        vt.push_back('{"p1_drop",    4'b0000, 4'b0000, 1'b1, 4'b0000, -1, 4'b0000});
        vt.push_back('{"p3_wr_arb",  4'b1000, 4'b1000, 1'b1, 4'b1000,  3, 4'b0000});
        for (int k = 0; k < 3; k++)
            vt.push_back('{"p3_wr_own", 4'b1000, 4'b1000, 1'b1, 4'b1000, 3, 4'b0111});
        vt.push_back('{"p3_release", 4'b0000, 4'b1000, 1'b1, 4'b0000, -1, 4'b0000});
        vt.push_back('{"p0_alone",   4'b0001, 4'b0000, 1'b1, 4'b0001,  0, 4'b0000});
        vt.push_back('{"p0_drop",    4'b0000, 4'b0000, 1'b1, 4'b0000, -1, 4'b0000});
`ifdef SNOOP_SRAM_PRIO_EN
        vt.push_back('{"p0p1_ptr1",  4'b0011, 4'b0000, 1'b1, 4'b0001,  0, 4'b0000});
`else
        vt.push_back('{"p0p1_ptr1",  4'b0011, 4'b0000, 1'b1, 4'b0010,  1, 4'b0000});
`endif
        vt.push_back('{"idle_end",   4'b0000, 4'b0000, 1'b1, 4'b0000, -1, 4'b0000});

        do_reset();
        foreach (vt[k]) begin
            @(negedge clk_i);
            drive(vt[k].rq, vt[k].we, vt[k].gi);
            #1;
            check($sformatf("%s[%0d]", vt[k].nm, k), vt[k].e_gnt, vt[k].e_sel, vt[k].e_upd);
        end

        // port 1 keeps requesting with port 2 waiting: owner through the revocation cycle, then port 2
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk_i);
            drive(4'b0110, 4'b0000, 1'b1);
            #1;
            check($sformatf("hold_c%0d", c), c <= 17 ? 4'b0010 : 4'b0100, c <= 17 ? 1 : 2, 4'b0000);
        end

        // reset asserted while port 2 owns the SRAM with a write
        do_reset();
        @(negedge clk_i);
        drive(4'b0100, 4'b0100, 1'b1);
        #1;
        check("r_arb", 4'b0100, 2, 4'b0000);
        @(negedge clk_i);
        #1;
        check("r_own", 4'b0100, 2, 4'b1011);
        #2;
        rst_ni = 1'b0;
        #1;
        check("r_async", 4'b0000, -1, 4'b0000);
        @(negedge clk_i);
        drive(4'b0000, 4'b0000, 1'b1);
        rst_ni = 1'b1;
        #1;
        check("r_after", 4'b0000, -1, 4'b0000);
        @(negedge clk_i);
        drive(4'b0100, 4'b0000, 1'b1);
        #1;
        check("r_rereq", 4'b0100, 2, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
